// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared definitions for the PS/2 key event decoder: prefix bytes, FSM states,
// event word layout and a BCD increment helper.
package ps2_defs;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_ERR0  = 8'h00;
    localparam logic [7:0] PS2_ERR1  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT
    } state_t;

    localparam int unsigned EV_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    // Increments the low `digits` BCD digits; all-9s wraps to zero.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v, input int unsigned digits);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < digits && carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Byte-side (ps2_keyboard FIFO) and event-side (valid/ready queue) signals of
// the key event decoder; master is the decoder, slave is its environment.
interface ps2_key_event_decoder_if;

    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (
        input  kb_data, kb_ready, kb_overflow, ev_ready,
        output kb_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
    );

    modport slave (
        output kb_data, kb_ready, kb_overflow, ev_ready,
        input  kb_nextdata_n, ev_valid, ev_code, ev_ext, ev_break
    );

endinterface

// File: rtl/ps2_key_event_decoder_key_event_fifo.sv
// Synchronous FIFO for decoded key events; a pop frees a slot for a write in
// the same cycle even when full.
module key_event_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Folds PS/2 E0/F0 prefixes into key events, queues them, and tracks held keys,
// a BCD press counter and the last key. TYPEMATIC_FILTER_EN drops repeat makes.
module ps2_key_event_decoder
    import ps2_defs::*;
#(
    parameter int unsigned EVQ_DEPTH  = 4,
    parameter int unsigned HELD_SLOTS = 4,
    parameter int unsigned CNT_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    ps2_key_event_decoder_if.master bus,
    output logic [4*CNT_DIGITS-1:0] press_cnt,
    output logic [7:0]              last_code,
    output logic                    last_ext,
    output logic [3:0]              held_cnt,
    output logic                    err,
    input  logic                    clr_err
);

    state_t state, state_d;

    logic [7:0]            byte_q;
    logic                  ext_pend, brk_pend;
    logic [2:0]            skip_cnt;
    logic [HELD_SLOTS-1:0] held_vld, held_ext;
    logic [7:0]            held_code [HELD_SLOTS];
    logic [HELD_SLOTS-1:0] hit_vec, free_sel, ins_mask, rm_mask;
    logic                  is_evt, is_make, is_brk, is_rep, new_make, tbl_full, err_set;
    logic                  q_wr, q_full, q_empty;
    logic [EV_W-1:0]       q_dout, ev_hold;

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (bus.kb_ready && !q_full) state_d = S_POP;
            S_POP:   state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.kb_nextdata_n = (state != S_POP);
    end

    always_ff @(posedge clk) begin
        if (!resetn)                                byte_q <= '0;
        else if (state == S_IDLE && state_d == S_POP) byte_q <= bus.kb_data;
    end

    always_comb begin
        hit_vec  = '0;
        free_sel = '0;
        for (int unsigned i = 0; i < HELD_SLOTS; i++) begin
            hit_vec[i] = held_vld[i] && held_code[i] == byte_q && held_ext[i] == ext_pend;
            if (!held_vld[i] && free_sel == '0) free_sel[i] = 1'b1;
        end
    end

    always_comb begin
        is_evt   = (state == S_POP) && skip_cnt == 3'd0 &&
                   byte_q != PS2_EXT && byte_q != PS2_BRK && byte_q != PS2_PAUSE &&
                   byte_q != PS2_ERR0 && byte_q != PS2_ERR1;
        is_make  = is_evt && !brk_pend;
        is_brk   = is_evt && brk_pend;
        is_rep   = is_make && (hit_vec != '0);
        new_make = is_make && !is_rep;
        tbl_full = new_make && (free_sel == '0);
        ins_mask = new_make ? free_sel : '0;
        rm_mask  = is_brk ? hit_vec : '0;
`ifdef TYPEMATIC_FILTER_EN
        q_wr     = is_evt && !is_rep;
`else
        q_wr     = is_evt;
`endif
        err_set  = bus.kb_overflow || tbl_full ||
                   ((state == S_POP) && skip_cnt == 3'd0 &&
                    (byte_q == PS2_ERR0 || byte_q == PS2_ERR1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            skip_cnt  <= '0;
            held_vld  <= '0;
            held_ext  <= '0;
            held_cnt  <= '0;
            press_cnt <= '0;
            last_code <= '0;
            last_ext  <= 1'b0;
            err       <= 1'b0;
            for (int unsigned i = 0; i < HELD_SLOTS; i++) held_code[i] <= '0;
        end else begin
            if (err_set)      err <= 1'b1;
            else if (clr_err) err <= 1'b0;

            if (state == S_POP) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else begin
                    case (byte_q)
                        PS2_EXT:   ext_pend <= 1'b1;
                        PS2_BRK:   brk_pend <= 1'b1;
                        PS2_PAUSE: skip_cnt <= 3'd7;
                        default: begin
                            ext_pend <= 1'b0;
                            brk_pend <= 1'b0;
                        end
                    endcase
                end
            end

            for (int unsigned i = 0; i < HELD_SLOTS; i++) begin
                if (ins_mask[i]) begin
                    held_code[i] <= byte_q;
                    held_ext[i]  <= ext_pend;
                end
            end
            held_vld <= (held_vld | ins_mask) & ~rm_mask;
            if (ins_mask != '0)     held_cnt <= held_cnt + 4'd1;
            else if (rm_mask != '0) held_cnt <= held_cnt - 4'd1;

            if (new_make) begin
                press_cnt <= bcd_inc(16'(press_cnt), CNT_DIGITS)[4*CNT_DIGITS-1:0];
                last_code <= byte_q;
                last_ext  <= ext_pend;
            end
        end
    end

    key_event_fifo #(
        .WIDTH(EV_W),
        .DEPTH(EVQ_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (q_wr),
        .din    ({ext_pend, brk_pend, byte_q}),
        .rd_en  (bus.ev_valid && bus.ev_ready),
        .dout   (q_dout),
        .full   (q_full),
        .empty  (q_empty)
    );

    // Head is tracked while non-empty so outputs hold after the queue drains.
    always_ff @(posedge clk) begin
        if (!resetn)       ev_hold <= '0;
        else if (!q_empty) ev_hold <= q_dout;
    end

    assign bus.ev_valid = !q_empty;
    assign {bus.ev_ext, bus.ev_break, bus.ev_code} = q_empty ? ev_hold : q_dout;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: prefix folding, held table, BCD
// counter, queue backpressure, error flag and mid-sequence reset.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       resetn;
    logic       clr_err;
    logic [7:0] press_cnt;
    logic [7:0] last_code;
    logic       last_ext;
    logic [3:0] held_cnt;
    logic       err;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] got [$];

    ps2_key_event_decoder_if bus();

    ps2_key_event_decoder #(
        .EVQ_DEPTH (4),
        .HELD_SLOTS(4),
        .CNT_DIGITS(2)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .press_cnt(press_cnt),
        .last_code(last_code),
        .last_ext (last_ext),
        .held_cnt (held_cnt),
        .err      (err),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ev_valid === 1'b1 && bus.ev_ready === 1'b1)
            got.push_back({bus.ev_ext, bus.ev_break, bus.ev_code});
    end

    function automatic logic [9:0] ev(input logic e, input logic b, input logic [7:0] c);
        return {e, b, c};
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = (got.size() > 0) ? got.pop_front() : 10'bx;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 bus.ev_ready = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn          = 1'b0;
        bus.kb_ready    = 1'b0;
        bus.kb_data     = 8'h00;
        bus.kb_overflow = 1'b0;
        clr_err         = 1'b0;
        cycles(2);
        resetn = 1'b1;
        got.delete();
    endtask

    task automatic present(input logic [7:0] b);
        @(negedge clk);
        bus.kb_data  = b;
        bus.kb_ready = 1'b1;
    endtask

    task automatic wait_pop(input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.kb_nextdata_n === 1'b0) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=no_pop expected=pop", tag);
        end
        bus.kb_ready = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        present(b);
        wait_pop("pop_timeout");
    endtask

    initial begin
        int lows;
        bus.ev_ready = 1'b1;
        resetn       = 1'b0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk1("rst_nextdata_n", bus.kb_nextdata_n, 1'b1);
        chk1("rst_ev_valid", bus.ev_valid, 1'b0);
        chk8("rst_ev_code", bus.ev_code, 8'h00);
        chk1("rst_ev_ext", bus.ev_ext, 1'b0);
        chk1("rst_ev_break", bus.ev_break, 1'b0);
        chk8("rst_press_cnt", press_cnt, 8'h00);
        chk8("rst_last_code", last_code, 8'h00);
        chk1("rst_last_ext", last_ext, 1'b0);
        chk8("rst_held_cnt", 8'(held_cnt), 8'h00);
        chk1("rst_err", err, 1'b0);

        // Latency: kb_ready at cycle N -> pop strobe at N+1 -> ev_valid at N+2
        set_ready(1'b0);
        present(8'h15);
        @(negedge clk);
        chk1("lat_pop_strobe", bus.kb_nextdata_n, 1'b0);
        chk1("lat_valid_n1", bus.ev_valid, 1'b0);
        bus.kb_ready = 1'b0;
        @(negedge clk);
        chk1("lat_strobe_one_cycle", bus.kb_nextdata_n, 1'b1);
        chk1("lat_valid_n2", bus.ev_valid, 1'b1);
        chk8("lat_head_code", bus.ev_code, 8'h15);
        chk8("held_after_make", 8'(held_cnt), 8'd1);
        set_ready(1'b1);
        send(8'hF0);
        send(8'h15);
        cycles(4);
        chk_ev("ev_15_make", ev(0, 0, 8'h15));
        chk_ev("ev_15_break", ev(0, 1, 8'h15));
        chk8("press_after_15", press_cnt, 8'h01);
        chk8("last_after_15", last_code, 8'h15);
        chk8("held_after_break", 8'(held_cnt), 8'd0);
        chk1("drained_valid", bus.ev_valid, 1'b0);
        chk8("hold_code", bus.ev_code, 8'h15);
        chk1("hold_break", bus.ev_break, 1'b1);

        // Extended make and break
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        cycles(4);
        chk_ev("ev_e075_make", ev(1, 0, 8'h75));
        chk_ev("ev_e075_break", ev(1, 1, 8'h75));
        chk8("last_code_75", last_code, 8'h75);
        chk1("last_ext_1", last_ext, 1'b1);
        chk8("press_after_75", press_cnt, 8'h02);

        // Typematic repeat
        do_reset();
        send(8'h15); send(8'h15); send(8'h15);
        cycles(4);
`ifdef TYPEMATIC_FILTER_EN
        chkn("rep_event_count", got.size(), 1);
        chk_ev("rep_ev0", ev(0, 0, 8'h15));
`else
        chkn("rep_event_count", got.size(), 3);
        chk_ev("rep_ev0", ev(0, 0, 8'h15));
        chk_ev("rep_ev1", ev(0, 0, 8'h15));
        chk_ev("rep_ev2", ev(0, 0, 8'h15));
`endif
        chk8("rep_press_cnt", press_cnt, 8'h01);
        chk8("rep_held_cnt", 8'(held_cnt), 8'd1);

        // Backpressure: queue of 4 blocks the 5th key byte
        do_reset();
        set_ready(1'b0);
        send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'h32); send(8'hF0); send(8'h32);
        present(8'h21);
        lows = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.kb_nextdata_n !== 1'b1) lows++;
        end
        chkn("bp_no_pop_when_full", lows, 0);
        chk1("bp_valid", bus.ev_valid, 1'b1);
        chkn("bp_nothing_delivered", got.size(), 0);
        set_ready(1'b1);
        wait_pop("bp_pop_timeout");
        send(8'hF0); send(8'h21);
        cycles(6);
        chkn("bp_event_count", got.size(), 6);
        chk_ev("bp_ev0", ev(0, 0, 8'h1C));
        chk_ev("bp_ev1", ev(0, 1, 8'h1C));
        chk_ev("bp_ev2", ev(0, 0, 8'h32));
        chk_ev("bp_ev3", ev(0, 1, 8'h32));
        chk_ev("bp_ev4", ev(0, 0, 8'h21));
        chk_ev("bp_ev5", ev(0, 1, 8'h21));

        // Held table overflow
        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        cycles(2);
        chk8("held_four", 8'(held_cnt), 8'd4);
        chk1("err_before_full", err, 1'b0);
        send(8'h34);
        cycles(3);
        chk8("held_stays_four", 8'(held_cnt), 8'd4);
        chk1("err_table_full", err, 1'b1);
        chkn("full_event_count", got.size(), 5);
        chk8("full_last_code", last_code, 8'h34);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk1("err_cleared", err, 1'b0);

        // Error bytes and overflow
        do_reset();
        send(8'hFF);
        cycles(3);
        chk1("err_ff_byte", err, 1'b1);
        chkn("err_ff_no_event", got.size(), 0);
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk1("err_clr2", err, 1'b0);
        @(negedge clk); bus.kb_overflow = 1'b1;
        @(negedge clk); bus.kb_overflow = 1'b0;
        chk1("err_overflow", err, 1'b1);

        // BCD counter wrap
        do_reset();
        for (int i = 0; i < 99; i++) begin
            send(8'h15); send(8'hF0); send(8'h15);
        end
        cycles(3);
        chk8("press_99", press_cnt, 8'h99);
        send(8'h15);
        cycles(3);
        chk8("press_wrap_00", press_cnt, 8'h00);

        // Reset discards a pending E0 prefix
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h75);
        cycles(4);
        chk_ev("rst_drops_prefix", ev(0, 0, 8'h75));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
